// File: rtl/tx_interleaver.sv
`default_nettype none
// ============================================================================
// Module   : tx_interleaver
// Brief    : 802.11a BPSK block interleaver (first permutation) using
//            ping-pong bit banks, serial in / serial out.
// Revision : 1.0 - initial release
// ============================================================================
module tx_interleaver #(
    parameter int NCBPS = 48
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iData,
    input  logic iValid,
    output logic oData,
    output logic oValid,
    output logic oSymStart,
    output logic oOvf
);

    localparam int            KW   = $clog2(NCBPS);
    localparam int            COLS = NCBPS / 16;
    localparam logic [KW-1:0] LAST = KW'(NCBPS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t           state;
    logic [NCBPS-1:0] bank [2];
    logic [1:0]       full;
    logic             wrSel;
    logic             rdSel;
    logic [KW-1:0]    kCnt;
    logic [KW-1:0]    rCnt;

    logic [KW-1:0]    wrAddr;
    logic             wrEn;
    logic             wrDone;
    logic             wrCommit;
    logic             rdStart;
    logic             rdLast;
    logic             otherFull;
    logic [1:0]       setMask;
    logic [1:0]       clrMask;

    assign wrAddr    = KW'(COLS * int'(kCnt[3:0]) + int'(kCnt >> 4));
    // A full bank is write-protected so an overflowing symbol cannot corrupt
    // data still waiting to be read out.
    assign wrEn      = iValid && !full[wrSel];
    assign wrDone    = iValid && (kCnt == LAST);
    assign wrCommit  = wrDone && !full[wrSel];
    assign rdStart   = full[rdSel];
    assign rdLast    = (state == READ) && (rCnt == LAST);
    // A completion landing in the other bank on this same edge keeps output gapless.
    assign otherFull = full[~rdSel] || (wrCommit && (wrSel != rdSel));
    assign setMask   = wrCommit ? (wrSel ? 2'b10 : 2'b01) : 2'b00;
    assign clrMask   = rdLast   ? (rdSel ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge iClk) begin
        if (wrEn) begin
            bank[wrSel][wrAddr] <= iData;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            kCnt      <= '0;
            rCnt      <= '0;
            full      <= 2'b00;
            wrSel     <= 1'b0;
            rdSel     <= 1'b0;
            state     <= IDLE;
            oData     <= 1'b0;
            oValid    <= 1'b0;
            oSymStart <= 1'b0;
            oOvf      <= 1'b0;
        end else begin
            if (iValid) begin
                if (wrDone) begin
                    kCnt <= '0;
                    if (full[wrSel]) begin
                        oOvf <= 1'b1;
                    end else begin
                        wrSel <= ~wrSel;
                    end
                end else begin
                    kCnt <= kCnt + KW'(1);
                end
            end

            full <= (full & ~clrMask) | setMask;

            case (state)
                IDLE: begin
                    if (rdStart) begin
                        oData     <= bank[rdSel][0];
                        oValid    <= 1'b1;
                        oSymStart <= 1'b1;
                        rCnt      <= KW'(1);
                        state     <= READ;
                    end else begin
                        oData     <= 1'b0;
                        oValid    <= 1'b0;
                        oSymStart <= 1'b0;
                    end
                end
                READ: begin
                    oData     <= bank[rdSel][rCnt];
                    oValid    <= 1'b1;
                    oSymStart <= (rCnt == '0);
                    if (rdLast) begin
                        rdSel <= ~rdSel;
                        rCnt  <= '0;
                        if (!otherFull) begin
                            state <= IDLE;
                        end
                    end else begin
                        rCnt <= rCnt + KW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_interleaver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tx_interleaver
// Brief    : Randomised scoreboard bench for tx_interleaver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_interleaver;

    localparam int N    = 48;
    localparam int COLS = N / 16;

    logic iClk   = 1'b0;
    logic iRst   = 1'b1;
    logic iData  = 1'b0;
    logic iValid = 1'b0;
    logic oData;
    logic oValid;
    logic oSymStart;
    logic oOvf;

    tx_interleaver #(.NCBPS(N)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iData     (iData),
        .iValid    (iValid),
        .oData     (oData),
        .oValid    (oValid),
        .oSymStart (oSymStart),
        .oOvf      (oOvf)
    );

    always #5 iClk = ~iClk;

    int         errors  = 0;
    int         checks  = 0;
    logic [1:0] expQ[$];     // {symStart, data}
    bit         inBuf[$];
    bit         outBuf[$];
    int         runLen  = 0;
    int         lastRun = 0;
    bit         keepExp = 1'b1;
    logic [1:0] e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every presented output bit is compared with the scoreboard head.
    always @(negedge iClk) begin
        if (oValid && !iRst) begin
            if (expQ.size() == 0) begin
                chk("unexpected output", 1, 0);
            end else begin
                e = expQ.pop_front();
                chk("data", int'(oData), int'(e[0]));
                chk("symStart", int'(oSymStart), int'(e[1]));
            end
            outBuf.push_back(oData);
            runLen++;
        end else begin
            if (runLen != 0) lastRun = runLen;
            runLen = 0;
        end
    end

    // Reference: output position j carries input bit k = 16*(j mod COLS) + j/COLS.
    task automatic modelBit(input bit d);
        inBuf.push_back(d);
        if (inBuf.size() == N) begin
            if (keepExp) begin
                for (int j = 0; j < N; j++) begin
                    expQ.push_back({1'(j == 0), inBuf[16 * (j % COLS) + j / COLS]});
                end
            end
            inBuf.delete();
        end
    endtask

    task automatic sendBits(input logic [3*N-1:0] d, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                @(posedge iClk); #1;
                iValid = 1'b0;
            end
            @(posedge iClk); #1;
            iValid = 1'b1;
            iData  = d[i];
            modelBit(d[i]);
        end
    endtask

    task automatic idle();
        @(posedge iClk); #1;
        iValid = 1'b0;
        iData  = 1'b0;
    endtask

    task automatic randData(output logic [3*N-1:0] d);
        for (int i = 0; i < 3 * N; i++) d[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic waitOut(input int n, input int budget);
        int c = 0;
        while (outBuf.size() < n && c < budget) begin
            @(negedge iClk);
            c++;
        end
        chk("output count", outBuf.size(), n);
        repeat (3) @(negedge iClk);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic asyncReset();
        #2;
        iRst   = 1'b1;
        iValid = 1'b0;
        #1;
        chk("reset oValid", int'(oValid), 0);
        chk("reset oData", int'(oData), 0);
        chk("reset oSymStart", int'(oSymStart), 0);
        chk("reset oOvf", int'(oOvf), 0);
        expQ.delete();
        inBuf.delete();
        @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
    endtask

    initial begin
        logic [3*N-1:0] d;
        int             kIn[3]  = '{1, 16, 47};
        int             pExp[3] = '{3, 1, 47};
        int             ones;
        int             pos;
        int             c;

        repeat (2) @(posedge iClk);
        @(negedge iClk);
        chk("init oValid", int'(oValid), 0);
        chk("init oData", int'(oData), 0);
        chk("init oSymStart", int'(oSymStart), 0);
        chk("init oOvf", int'(oOvf), 0);
        iRst = 1'b0;

        // Single-bit mapping
        for (int t = 0; t < 3; t++) begin
            d = '0;
            d[kIn[t]] = 1'b1;
            outBuf.delete();
            sendBits(d, N, 1'b0);
            idle();
            waitOut(N, 200);
            ones = 0;
            pos  = -1;
            foreach (outBuf[i]) if (outBuf[i]) begin ones++; pos = i; end
            chk($sformatf("map k=%0d position", kIn[t]), pos, pExp[t]);
            chk($sformatf("map k=%0d ones", kIn[t]), ones, 1);
        end

        // Latency/framing, gapless then gapped input
        for (int g = 0; g < 2; g++) begin
            randData(d);
            outBuf.delete();
            sendBits(d, N, 1'(g));
            idle();
            @(negedge iClk);
            chk("oValid at E0", int'(oValid), 0);
            @(negedge iClk);
            chk("oValid at E0+1", int'(oValid), 1);
            chk("oSymStart at E0+1", int'(oSymStart), 1);
            waitOut(N, 200);
            chk("run length", lastRun, N);
        end

        // Back-to-back symbols
        randData(d);
        outBuf.delete();
        sendBits(d, 3 * N, 1'b0);
        idle();
        waitOut(3 * N, 400);
        chk("back-to-back run length", lastRun, 3 * N);
        chk("back-to-back oOvf", int'(oOvf), 0);

        // Reset after 20 input bits, then a fresh symbol
        randData(d);
        sendBits(d, 20, 1'b0);
        @(negedge iClk);
        asyncReset();
        randData(d);
        outBuf.delete();
        sendBits(d, N, 1'b0);
        idle();
        waitOut(N, 200);

        // Reset during output bit 10, then a fresh symbol
        randData(d);
        outBuf.delete();
        sendBits(d, N, 1'b0);
        idle();
        c = 0;
        while (outBuf.size() < 10 && c < 200) begin
            @(negedge iClk);
            c++;
        end
        chk("reached output bit 10", outBuf.size(), 10);
        asyncReset();
        repeat (3) @(negedge iClk);
        chk("no output after reset", int'(oValid), 0);
        randData(d);
        outBuf.delete();
        sendBits(d, N, 1'b0);
        idle();
        waitOut(N, 200);

        // Overflow with the reader held in IDLE
        force dut.rdStart = 1'b0;
        randData(d);
        outBuf.delete();
        sendBits(d, 2 * N, 1'b0);
        idle();
        @(negedge iClk);
        chk("oOvf after 2 symbols", int'(oOvf), 0);
        randData(d);
        keepExp = 1'b0;
        sendBits(d, N, 1'b0);
        keepExp = 1'b1;
        idle();
        @(negedge iClk);
        chk("oOvf after 3rd symbol", int'(oOvf), 1);
        chk("no output while stalled", outBuf.size(), 0);
        release dut.rdStart;
        waitOut(2 * N, 400);
        chk("post-stall run length", lastRun, 2 * N);
        chk("oOvf sticky", int'(oOvf), 1);
        @(negedge iClk);
        asyncReset();

        chk("scoreboard drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
